conv2d_axi_lite_master: RTL and testbench

CONV2D_AXI_LITE_MASTER -- requirements
Module: conv2d_axi_lite_master

---
 rtl/conv2d_axi_pkg.sv | 46 ++++
 rtl/conv2d_axi_lite_master_if.sv | 50 +++++
 rtl/conv2d_axi_lite_master.sv | 266 ++++++++++++++++++++++++++
 tb/tb_conv2d_axi_lite_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2d_axi_pkg.sv
// Shared register map, response code, job payload and FSM state encoding for the conv2d AXI-Lite master.
package conv2d_axi_pkg;

  localparam int unsigned NUM_TAPS   = 9;
  localparam int unsigned TAP_BITS   = 8;
  localparam int unsigned NUM_CFG_WR = 2 * NUM_TAPS + 1;

  localparam int unsigned CTRL_OFFS = 32'h00;
  localparam int unsigned IN_BASE   = 32'h04;
  localparam int unsigned W_BASE    = 32'h28;
  localparam int unsigned OUT_OFFS  = 32'h4C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    POLL_AR,
    POLL_R,
    OUT_AR,
    OUT_R,
    CLR_REQ,
    CLR_RESP,
    DONE
  } state_e;

  typedef struct packed {
    logic [NUM_TAPS*TAP_BITS-1:0] pix;
    logic [NUM_TAPS*TAP_BITS-1:0] wgt;
  } job_t;

  // Byte offset of configuration write number idx: pixels, then weights, then CTRL.
  function automatic int unsigned cfg_offs(input int unsigned idx);
    int unsigned offs;
    if (idx < NUM_TAPS) begin
      offs = IN_BASE + 4 * idx;
    end else if (idx < 2 * NUM_TAPS) begin
      offs = W_BASE + 4 * (idx - NUM_TAPS);
    end else begin
      offs = CTRL_OFFS;
    end
    return offs;
  endfunction

endpackage

// File: rtl/conv2d_axi_lite_master_if.sv
// AXI4-Lite master-side bus bundle for the conv2d accelerator register block.
interface conv2d_axi_lite_master_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );

endinterface

// File: rtl/conv2d_axi_lite_master.sv
// Drives one 3x3 convolution job through the accelerator's AXI-Lite registers and returns the result.
// Optional poll timeout: define CONV_MASTER_TIMEOUT_EN.
module conv2d_axi_lite_master
  import conv2d_axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned POLL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [71:0] cmd_pix,
  input  logic [71:0] cmd_wgt,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        res_err,
  conv2d_axi_lite_master_if.master m_axi
);

  localparam int unsigned IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_CFG_IDX = IDX_W'(NUM_CFG_WR - 1);

  state_e                state_q, state_d;
  job_t                  job_q, job_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  err_q, err_d;
  logic                  res_valid_q, res_valid_d;
  logic [15:0]           res_data_q, res_data_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  load_cfg_c;
  logic                  start_clr_c;
  logic                  start_poll_c;
  logic                  aw_done_c;
  logic                  w_done_c;

`ifdef CONV_MASTER_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);
  logic [POLL_W-1:0] poll_q, poll_d;
`else
  // Without the timeout the poll loop is unbounded and the limit has no effect.
  localparam int unsigned poll_limit_unused = POLL_LIMIT;
`endif

  // Only the low half-word of a read carries the result/status.
  logic rdata_hi_unused;
  assign rdata_hi_unused = ^m_axi.M_AXI_RDATA[DATA_WIDTH-1:16];

  // Configuration word: selected 8-bit tap sign-extended, or CTRL start value.
  function automatic logic [DATA_WIDTH-1:0] cfg_data(input job_t job, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    logic [6:0] lsb;
    if (idx < IDX_W'(NUM_TAPS)) begin
      lsb = 7'(8 * 32'(idx));
      b   = job.pix[lsb +: 8];
    end else if (idx < IDX_W'(2 * NUM_TAPS)) begin
      lsb = 7'(8 * (32'(idx) - NUM_TAPS));
      b   = job.wgt[lsb +: 8];
    end else begin
      lsb = '0;
      b   = 8'h01;
    end
    return {{(DATA_WIDTH-8){b[7]}}, b};
  endfunction

  always_comb begin
    state_d      = state_q;
    job_d        = job_q;
    idx_d        = idx_q;
    err_d        = err_q;
    res_valid_d  = 1'b0;
    res_data_d   = res_data_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wdata_d      = wdata_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    load_cfg_c   = 1'b0;
    start_clr_c  = 1'b0;
    start_poll_c = 1'b0;
    aw_done_c    = !awvalid_q || m_axi.M_AXI_AWREADY;
    w_done_c     = !wvalid_q || m_axi.M_AXI_WREADY;
`ifdef CONV_MASTER_TIMEOUT_EN
    poll_d       = poll_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          job_d      = '{pix: cmd_pix, wgt: cmd_wgt};
          err_d      = 1'b0;
          idx_d      = '0;
          load_cfg_c = 1'b1;
          state_d    = WR_REQ;
        end
      end
      // AW and W retire independently; the response phase waits for both.
      WR_REQ, CLR_REQ: begin
        if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.M_AXI_WREADY) wvalid_d = 1'b0;
        if (aw_done_c && w_done_c) begin
          bready_d = 1'b1;
          state_d  = (state_q == WR_REQ) ? WR_RESP : CLR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          if (m_axi.M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
          if (idx_q == LAST_CFG_IDX) begin
            start_poll_c = 1'b1;
`ifdef CONV_MASTER_TIMEOUT_EN
            poll_d       = '0;
`endif
          end else begin
            idx_d      = idx_q + IDX_W'(1);
            load_cfg_c = 1'b1;
          end
        end
      end
      POLL_AR, OUT_AR: begin
        if (m_axi.M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = (state_q == POLL_AR) ? POLL_R : OUT_R;
        end
      end
      POLL_R: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (m_axi.M_AXI_RRESP != RESP_OKAY) err_d = 1'b1;
          if (m_axi.M_AXI_RDATA[1]) begin
            arvalid_d = 1'b1;
            araddr_d  = ADDR_WIDTH'(OUT_OFFS);
            state_d   = OUT_AR;
          end else begin
`ifdef CONV_MASTER_TIMEOUT_EN
            if (poll_q == POLL_W'(POLL_LIMIT - 1)) begin
              err_d       = 1'b1;
              res_data_d  = '0;
              start_clr_c = 1'b1;
            end else begin
              poll_d       = poll_q + POLL_W'(1);
              start_poll_c = 1'b1;
            end
`else
            start_poll_c = 1'b1;
`endif
          end
        end
      end
      OUT_R: begin
        if (m_axi.M_AXI_RVALID) begin
          rready_d    = 1'b0;
          if (m_axi.M_AXI_RRESP != RESP_OKAY) err_d = 1'b1;
          res_data_d  = m_axi.M_AXI_RDATA[15:0];
          start_clr_c = 1'b1;
        end
      end
      CLR_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d    = 1'b0;
          if (m_axi.M_AXI_BRESP != RESP_OKAY) err_d = 1'b1;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_cfg_c) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = ADDR_WIDTH'(cfg_offs(32'(idx_d)));
      wdata_d   = cfg_data(job_d, idx_d);
      state_d   = WR_REQ;
    end
    if (start_poll_c) begin
      arvalid_d = 1'b1;
      araddr_d  = ADDR_WIDTH'(CTRL_OFFS);
      state_d   = POLL_AR;
    end
    if (start_clr_c) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = ADDR_WIDTH'(CTRL_OFFS);
      wdata_d   = '0;
      state_d   = CLR_REQ;
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      job_q       <= '0;
      idx_q       <= '0;
      cmd_ready_q <= 1'b1;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
`ifdef CONV_MASTER_TIMEOUT_EN
      poll_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      job_q       <= job_d;
      idx_q       <= idx_d;
      cmd_ready_q <= cmd_ready_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
`ifdef CONV_MASTER_TIMEOUT_EN
      poll_q      <= poll_d;
`endif
    end
  end

  assign cmd_ready            = cmd_ready_q;
  assign res_valid            = res_valid_q;
  assign res_data             = res_data_q;
  assign res_err              = err_q;
  assign m_axi.M_AXI_AWADDR   = awaddr_q;
  assign m_axi.M_AXI_AWVALID  = awvalid_q;
  assign m_axi.M_AXI_WDATA    = wdata_q;
  assign m_axi.M_AXI_WVALID   = wvalid_q;
  assign m_axi.M_AXI_BREADY   = bready_q;
  assign m_axi.M_AXI_ARADDR   = araddr_q;
  assign m_axi.M_AXI_ARVALID  = arvalid_q;
  assign m_axi.M_AXI_RREADY   = rready_q;

endmodule

// File: tb/tb_conv2d_axi_lite_master.sv
// Directed bench for conv2d_axi_lite_master with a small AXI-Lite accelerator slave model.
// Covers both builds of CONV_MASTER_TIMEOUT_EN.
module tb_conv2d_axi_lite_master;

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned PL = 16;

  typedef struct {
    logic [71:0] pix;
    logic [71:0] wgt;
    int          aw_dly;
    int          w_dly;
    int          done_poll;
    int          slverr_wr;
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_polls;
    logic        exp_out;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [71:0] cmd_pix;
  logic [71:0] cmd_wgt;
  logic        res_valid;
  logic [15:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;
  int cur_job = 0;
  int overlap_cnt = 0;

  conv2d_axi_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  conv2d_axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_LIMIT(PL)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_pix   (cmd_pix),
    .cmd_wgt   (cmd_wgt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_err   (res_err),
    .m_axi     (axi)
  );

  always #5 clk = ~clk;

  // Accelerator slave model: configurable ready delays, BRESP fault injection, done-on-Nth-poll.
  int          aw_delay = 0, w_delay = 0, done_poll = 1, slverr_wr = -1;
  logic        slv_clr = 1'b0;
  int          aw_cnt, w_cnt, wr_num, poll_num;
  logic        aw_got, w_got, bvalid_s, rvalid_s;
  logic [AW-1:0] aw_addr_s;
  logic [DW-1:0] w_data_s, rdata_s;
  logic [1:0]  bresp_s;
  logic [DW-1:0] regs [32];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [AW-1:0] rd_addr_q [$];

  assign axi.M_AXI_AWREADY = axi.M_AXI_AWVALID && !aw_got && (aw_cnt >= aw_delay);
  assign axi.M_AXI_WREADY  = axi.M_AXI_WVALID && !w_got && (w_cnt >= w_delay);
  assign axi.M_AXI_BVALID  = bvalid_s;
  assign axi.M_AXI_BRESP   = bresp_s;
  assign axi.M_AXI_ARREADY = axi.M_AXI_ARVALID && !rvalid_s;
  assign axi.M_AXI_RVALID  = rvalid_s;
  assign axi.M_AXI_RDATA   = rdata_s;
  assign axi.M_AXI_RRESP   = 2'b00;

  function automatic logic [DW-1:0] conv_out();
    int acc = 0;
    int p, w;
    logic [7:0] pb, wb;
    for (int k = 0; k < 9; k++) begin
      pb = regs[1+k][7:0];
      wb = regs[10+k][7:0];
      p = $signed(pb);
      w = $signed(wb);
      acc += p * w;
    end
    return {16'h0, acc[15:0]};
  endfunction

  always @(posedge clk) begin
    if (rst || slv_clr) begin
      aw_cnt <= 0; w_cnt <= 0; wr_num <= 0; poll_num <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0;
      aw_addr_s <= '0; w_data_s <= '0; rdata_s <= '0; bresp_s <= 2'b00;
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    end else begin
      if (axi.M_AXI_AWVALID && axi.M_AXI_AWREADY) begin
        aw_got <= 1'b1; aw_addr_s <= axi.M_AXI_AWADDR; aw_cnt <= 0;
      end else if (axi.M_AXI_AWVALID && !aw_got) aw_cnt <= aw_cnt + 1;
      if (axi.M_AXI_WVALID && axi.M_AXI_WREADY) begin
        w_got <= 1'b1; w_data_s <= axi.M_AXI_WDATA; w_cnt <= 0;
      end else if (axi.M_AXI_WVALID && !w_got) w_cnt <= w_cnt + 1;
      if (aw_got && w_got && !bvalid_s) begin
        regs[aw_addr_s[AW-1:2]] <= w_data_s;
        wr_addr_q.push_back(aw_addr_s);
        wr_data_q.push_back(w_data_s);
        bresp_s  <= (wr_num == slverr_wr) ? 2'b10 : 2'b00;
        wr_num   <= wr_num + 1;
        bvalid_s <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (bvalid_s && axi.M_AXI_BREADY) bvalid_s <= 1'b0;
      if (axi.M_AXI_ARVALID && axi.M_AXI_ARREADY) begin
        rd_addr_q.push_back(axi.M_AXI_ARADDR);
        rvalid_s <= 1'b1;
        if (axi.M_AXI_ARADDR == 7'h00) begin
          poll_num <= poll_num + 1;
          rdata_s  <= (done_poll != 0 && poll_num + 1 >= done_poll) ? 32'h2 : 32'h0;
        end else begin
          rdata_s <= conv_out();
        end
      end
      if (rvalid_s && axi.M_AXI_RREADY) rvalid_s <= 1'b0;
    end
  end

  // A write phase and a read phase must never be active together.
  always @(negedge clk) begin
    if (!rst && (axi.M_AXI_AWVALID || axi.M_AXI_WVALID || axi.M_AXI_BREADY) &&
        (axi.M_AXI_ARVALID || axi.M_AXI_RREADY))
      overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (job %0d) actual=0x%0h required=0x%0h", name, cur_job, act, exp);
    end
  endtask

  task automatic exp_wr(input vec_t v, input int i, output logic [AW-1:0] ea, output logic [DW-1:0] ed);
    logic [7:0] b;
    if (i < 9) begin
      ea = AW'(4 + 4 * i);
      b  = v.pix[8*i +: 8];
    end else if (i < 18) begin
      ea = AW'(8'h28 + 4 * (i - 9));
      b  = v.wgt[8*(i-9) +: 8];
    end else if (i == 18) begin
      ea = 7'h00;
      b  = 8'h01;
    end else begin
      ea = 7'h00;
      b  = 8'h00;
    end
    ed = {{24{b[7]}}, b};
  endtask

  task automatic start_job(input vec_t v);
    aw_delay = v.aw_dly; w_delay = v.w_dly; done_poll = v.done_poll; slverr_wr = v.slverr_wr;
    slv_clr = 1'b1;
    @(negedge clk);
    slv_clr = 1'b0;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_pix = v.pix; cmd_wgt = v.wgt;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_pix = ~v.pix; cmd_wgt = ~v.wgt;
    check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  task automatic run_job(input vec_t v);
    int n;
    int polls;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    start_job(v);
    n = 0;
    while (res_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", 32'(res_valid), 32'd1);
    check("res_data", 32'(res_data), 32'(v.exp_res));
    check("res_err", 32'(res_err), 32'(v.exp_err));
    check("wr_count", 32'(wr_addr_q.size()), 32'd20);
    for (int i = 0; i < 20 && i < wr_addr_q.size(); i++) begin
      exp_wr(v, i, ea, ed);
      check("wr_addr", 32'(wr_addr_q[i]), 32'(ea));
      check("wr_data", wr_data_q[i], ed);
    end
    polls = 0;
    foreach (rd_addr_q[i]) if (rd_addr_q[i] == 7'h00) polls++;
    check("poll_count", 32'(polls), 32'(v.exp_polls));
    check("rd_count", 32'(rd_addr_q.size()), 32'(v.exp_polls + (v.exp_out ? 1 : 0)));
    if (v.exp_out && rd_addr_q.size() > 0) check("out_rd_addr", 32'(rd_addr_q[$]), 32'h4C);
    @(negedge clk);
    check("res_valid_pulse", 32'(res_valid), 32'd0);
    check("cmd_ready_after", 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs [$];
  vec_t v;
  int   n;
  int   rv_seen;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_pix = '0; cmd_wgt = '0;
    for (int i = 0; i < 32; i++) regs[i] = '0;

    //            pix                       wgt                 awd wd dn  slv  exp_res   err polls out
    vecs.push_back('{{9{8'h01}},            {9{8'h01}},          0, 0, 1,  -1, 16'h0009, 1'b0, 1, 1'b1});
    vecs.push_back('{{9{8'hFF}},            {9{8'h7F}},          3, 0, 1,  -1, 16'hFB89, 1'b0, 1, 1'b1});
    vecs.push_back('{72'h080706050403020100, {9{8'h02}},         0, 1, 4,  -1, 16'h0048, 1'b0, 4, 1'b1});
    vecs.push_back('{{9{8'h02}},            {9{8'h03}},          0, 0, 1,  13, 16'h0036, 1'b1, 1, 1'b1});
    vecs.push_back('{{9{8'h01}},            {9{8'h01}},          0, 0, 1,  -1, 16'h0009, 1'b0, 1, 1'b1});
    vecs.push_back('{{9{8'h80}},            {9{8'h80}},          0, 2, 2,  -1, 16'h4000, 1'b0, 2, 1'b1});
`ifdef CONV_MASTER_TIMEOUT_EN
    vecs.push_back('{{9{8'h01}},            {9{8'h01}},          0, 0, 0,  -1, 16'h0000, 1'b1, 16, 1'b0});
`endif

    repeat (3) @(negedge clk);
    check("rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("rst_wvalid", 32'(axi.M_AXI_WVALID), 32'd0);
    check("rst_bready", 32'(axi.M_AXI_BREADY), 32'd0);
    check("rst_arvalid", 32'(axi.M_AXI_ARVALID), 32'd0);
    check("rst_rready", 32'(axi.M_AXI_RREADY), 32'd0);
    check("rst_awaddr", 32'(axi.M_AXI_AWADDR), 32'd0);
    check("rst_araddr", 32'(axi.M_AXI_ARADDR), 32'd0);
    check("rst_wdata", axi.M_AXI_WDATA, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_job = i;
      run_job(vecs[i]);
    end

`ifndef CONV_MASTER_TIMEOUT_EN
    // Done never set: polling continues indefinitely and no result appears.
    cur_job = 100;
    v = '{{9{8'h01}}, {9{8'h01}}, 0, 0, 0, -1, 16'h0, 1'b0, 0, 1'b0};
    start_job(v);
    rv_seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("no_timeout_res_valid", 32'(rv_seen), 32'd0);
    check("no_timeout_polls", 32'(rd_addr_q.size() > 16), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset while the pixel 5 write is on the bus.
    cur_job = 200;
    v = vecs[0];
    v.aw_dly = 2;
    start_job(v);
    n = 0;
    while (!(axi.M_AXI_AWVALID && axi.M_AXI_AWADDR == 7'h18) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached_px5", 32'(axi.M_AXI_AWADDR), 32'h18);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_awvalid", 32'(axi.M_AXI_AWVALID), 32'd0);
    check("mid_rst_wvalid", 32'(axi.M_AXI_WVALID), 32'd0);
    check("mid_rst_arvalid", 32'(axi.M_AXI_ARVALID), 32'd0);
    check("mid_rst_bready", 32'(axi.M_AXI_BREADY), 32'd0);
    check("mid_rst_rready", 32'(axi.M_AXI_RREADY), 32'd0);
    rst = 1'b0;
    rv_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    check("mid_rst_no_res_valid", 32'(rv_seen), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_res_data", 32'(res_data), 32'd0);

    // A clean job still completes after the abandoned one.
    cur_job = 201;
    run_job(vecs[0]);

    check("wr_rd_overlap", 32'(overlap_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
